// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single 256-bit off-chip data memory between the instruction
//   cache refill path (port 0) and the data cache miss/write-back path
//   (port 1). One requester is granted at a time; its request is registered
//   and held toward memory until the memory acks or the wait counter expires.
//   The read line and a one-cycle ack are routed back to the owner only.
//
// Ports
//   clk_i, rst_i          clock (rising edge), async active-low reset
//   pX_enable_i           port X request, held until pX_ack_o
//   pX_write_i            port X write (1) / read (0)
//   pX_addr_i [31:0]      port X line address
//   pX_data_i [255:0]     port X write line
//   pX_ack_o              one-cycle completion pulse to port X
//   pX_data_o [255:0]     read line to port X, valid with pX_ack_o
//   mem_enable_o          request to memory
//   mem_write_o           write strobe to memory
//   mem_addr_o [31:0]     address to memory
//   mem_data_o [255:0]    write line to memory
//   mem_data_i [255:0]    read line from memory
//   mem_ack_i             memory completion pulse
//   owner_o               currently granted port (valid in BUSY)
//   err_timeout_o         sticky flag: a transaction was aborted on timeout
//
// States
//   state   | meaning
//   IDLE    | no transaction; arbitrate among pending enables
//   BUSY    | request held toward memory, waiting for mem_ack_i
//   RELEASE | single cycle in which the owner's ack pulse is visible
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic         clk_i,
  input  logic         rst_i,

  input  logic         p0_enable_i,
  input  logic         p0_write_i,
  input  logic [31:0]  p0_addr_i,
  input  logic [255:0] p0_data_i,
  output logic         p0_ack_o,
  output logic [255:0] p0_data_o,

  input  logic         p1_enable_i,
  input  logic         p1_write_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [255:0] p1_data_i,
  output logic         p1_ack_o,
  output logic [255:0] p1_data_o,

  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,

  output logic         owner_o,
  output logic         err_timeout_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  // 1023 -> 10-bit counter
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // The counter is cleared on grant and increments once per BUSY cycle, so it
  // holds TIMEOUT_CYCLES-1 during the last BUSY cycle allowed.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q,    state_d;
  logic             ptr_q,      ptr_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             err_q,      err_d;
  logic             owner_q,    owner_d;
  logic             mem_en_q,   mem_en_d;
  logic             mem_we_q,   mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [255:0]     mem_data_q, mem_data_d;
  logic             p0_ack_q,   p0_ack_d;
  logic             p1_ack_q,   p1_ack_d;
  logic [255:0]     p0_data_q,  p0_data_d;
  logic [255:0]     p1_data_q,  p1_data_d;

  logic             any_req;
  logic             winner;

  assign any_req = p0_enable_i | p1_enable_i;

  // With a single requester it wins outright; on contention the pointer
  // decides in round-robin mode, otherwise the dcache port always wins.
  always_comb begin
    winner = p1_enable_i;
    if (p0_enable_i && p1_enable_i) begin
      winner = (ROUND_ROBIN != 0) ? ptr_q : 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    owner_d    = owner_q;
    mem_en_d   = mem_en_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    p0_ack_d   = 1'b0;
    p1_ack_d   = 1'b0;
    p0_data_d  = p0_data_q;
    p1_data_d  = p1_data_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d    = winner;
          mem_en_d   = 1'b1;
          mem_we_d   = winner ? p1_write_i : p0_write_i;
          mem_addr_d = winner ? p1_addr_i  : p0_addr_i;
          mem_data_d = winner ? p1_data_i  : p0_data_i;
          cnt_d      = '0;
          state_d    = S_BUSY;
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ack_i) begin
          // The memory's answer takes precedence over a simultaneous timeout.
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (owner_q) begin
            p1_data_d = mem_data_i;
            p1_ack_d  = 1'b1;
          end else begin
            p0_data_d = mem_data_i;
            p0_ack_d  = 1'b1;
          end
          ptr_d   = ~owner_q;
          state_d = S_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          // Abort without acking; the owner keeps its enable up and is
          // simply arbitrated again from IDLE.
          err_d    = 1'b1;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      S_RELEASE: begin
        state_d = S_IDLE;
      end

      default: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      ptr_q      <= 1'b1;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      owner_q    <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      p0_data_q  <= '0;
      p1_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      owner_q    <= owner_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      p0_ack_q   <= p0_ack_d;
      p1_ack_q   <= p1_ack_d;
      p0_data_q  <= p0_data_d;
      p1_data_q  <= p1_data_d;
    end
  end

  assign p0_ack_o      = p0_ack_q;
  assign p1_ack_o      = p1_ack_q;
  assign p0_data_o     = p0_data_q;
  assign p1_data_o     = p1_data_q;
  assign mem_enable_o  = mem_en_q;
  assign mem_write_o   = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_data_o    = mem_data_q;
  assign owner_o       = owner_q;
  assign err_timeout_o = err_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single 256-bit off-chip data memory between the instruction-cache refill path (port 0) and the dcache_top miss/write-back path (port 1).
- Sits between the caches and the memory model, which takes an enable/write/addr/data request and answers with a one-cycle ack.
- Grants one requester at a time, registers and holds its request toward memory, routes the read line and ack back, and flags stuck transactions.

Parameters:
- ROUND_ROBIN, 1: 1 = alternate priority after each grant; 0 = fixed priority, port 1 (dcache) wins.
- TIMEOUT_CYCLES, 1023: maximum cycles in BUSY before abort; width of wait counter = 10 bits.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-low
- p0_enable_i  in  1  port 0 request; held high until p0_ack_o
- p0_write_i  in  1  port 0 write (1) / read (0)
- p0_addr_i  in  32  port 0 line address
- p0_data_i  in  256  port 0 write line
- p0_ack_o  out  1  one-cycle completion pulse to port 0
- p0_data_o  out  256  read line to port 0, valid with p0_ack_o
- p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_ack_o, p1_data_o: same as port 0, for port 1
- mem_enable_o  out  1  request to memory
- mem_write_o  out  1  write strobe to memory
- mem_addr_o  out  32  address to memory
- mem_data_o  out  256  write line to memory
- mem_data_i  in  256  read line from memory
- mem_ack_i  in  1  memory completion pulse
- owner_o  out  1  port currently granted (valid in BUSY)
- err_timeout_o  out  1  sticky timeout flag

Behaviour:
- States: IDLE, BUSY, RELEASE.
- Reset, asynchronous, rst_i=0: state=IDLE; all outputs 0; priority pointer favours port 1; wait counter 0; err_timeout_o=0.
- IDLE:
  - No enable asserted: stay in IDLE.
  - Otherwise select a winner. With both requesting: ROUND_ROBIN=1 picks the pointer port; ROUND_ROBIN=0 picks port 1.
  - On the edge, latch the winner's write/addr/data into the mem_* output registers, set owner_o, set mem_enable_o=1, clear the wait counter, go to BUSY.
  - First request cycle N gives mem_enable_o=1 at N+1.
- BUSY:
  - mem_* outputs held constant; the requester's inputs are not re-sampled.
  - Wait counter increments each cycle.
  - mem_ack_i=1:
    - mem_enable_o←0, mem_write_o←0.
    - px_data_o←mem_data_i for the owner, read or write.
    - px_ack_o←1 for the owner only.
    - Pointer ← other port.
    - Go to RELEASE.
  - Ack in cycle M gives the owner ack in cycle M+1.
- RELEASE:
  - Exactly one cycle; the ack pulse is visible here.
  - px_ack_o←0 on exit; go to IDLE.
  - The requester drops enable during RELEASE, so IDLE never double-grants a finished request.
- Timeout:
  - Counter reaching TIMEOUT_CYCLES in BUSY without mem_ack_i: set err_timeout_o=1 (sticky until reset).
  - Drop mem_enable_o and go to IDLE.
  - No ack is issued to the owner; the owner stays pending and is re-arbitrated.
- Non-owner ports never see ack. Their data_o holds its last value; only the owner's data_o updates on ack.
- A mem_ack_i while in IDLE or RELEASE is ignored.
- An enable that falls before ack (protocol violation) does not abort the transaction; it completes and ack is still pulsed.
- Asynchronous reset mid-BUSY: immediate return to IDLE, mem_enable_o=0 with no glitch to any ack.
- Both ports requesting continuously with ROUND_ROBIN=1: grants alternate 1,0,1,0…

Test Plan:
- Reset: hold rst_i=0 for 3 cycles with both enables high → all outputs 0 and state IDLE. Release → mem_enable_o=1 one cycle later with owner_o=1 and mem_addr_o=p1_addr_i.
- Single read: p0 read at addr 0x400, memory acks after 10 cycles with data 0xA5…A5 → p0_ack_o high exactly 1 cycle with p0_data_o=0xA5…A5; p1_ack_o stays 0; mem_write_o stays 0.
- Single write: p1 write addr 0x80 with data pattern D → mem_write_o=1, mem_addr_o=0x80, mem_data_o=D held stable for every BUSY cycle; p1_ack_o pulses once.
- Contention, ROUND_ROBIN=1, both ports request continuously for 4 transactions → owner sequence 1,0,1,0. With ROUND_ROBIN=0 → 1,1,1,1 while p1 stays asserted.
- Timeout: TIMEOUT_CYCLES=8, memory never acks → err_timeout_o=1 after 8 BUSY cycles, mem_enable_o=0, no ack. Memory then acks the re-grant → normal completion; err_timeout_o remains 1.
- Reset mid-transaction: assert rst_i=0 at BUSY cycle 3 → mem_enable_o=0 immediately, no ack pulse, IDLE after release.
